// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, slot indices and the
// fixed service-priority picker (write, then data read, then instruction read).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef logic [1:0] slot_idx_t;

  localparam int        NUM_SLOTS = 3;
  localparam slot_idx_t SLOT_W    = 2'd0;
  localparam slot_idx_t SLOT_DR   = 2'd1;
  localparam slot_idx_t SLOT_IR   = 2'd2;

  function automatic slot_idx_t pick_slot(input logic [NUM_SLOTS-1:0] pend);
    if (pend[SLOT_W]) begin
      pick_slot = SLOT_W;
    end else if (pend[SLOT_DR]) begin
      pick_slot = SLOT_DR;
    end else begin
      pick_slot = SLOT_IR;
    end
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// One captured core request: address, write data/strobes and a pending flag.
module mem_arb_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        pending,
  output logic [31:0] held_addr,
  output logic [31:0] held_wdata,
  output logic [3:0]  held_wstrb
);

  // Load on capture, drop the pending flag once the transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      held_addr  <= 32'h0;
      held_wdata <= 32'h0;
      held_wstrb <= 4'h0;
    end else if (load) begin
      pending    <= 1'b1;
      held_addr  <= addr;
      held_wdata <= wdata;
      held_wstrb <= wstrb;
    end else if (clear) begin
      pending    <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-read, data-read and data-write requests from the core
// onto a single request/acknowledge memory channel, with an optional timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT  = 256,
  parameter int TO_WIDTH = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_WSTRB,
  output logic [31:0] M_WDATA,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA,
  output logic        ERR
);

  logic [NUM_SLOTS-1:0] cap_s, pend_s, eff_pend_s, clr_s, pend_next_s;
  logic [31:0] in_addr_s   [NUM_SLOTS];
  logic [31:0] in_wdata_s  [NUM_SLOTS];
  logic [3:0]  in_wstrb_s  [NUM_SLOTS];
  logic [31:0] held_addr_s [NUM_SLOTS];
  logic [31:0] held_wdata_s[NUM_SLOTS];
  logic [3:0]  held_wstrb_s[NUM_SLOTS];
  logic [31:0] eff_addr_s  [NUM_SLOTS];
  logic [31:0] eff_wdata_s [NUM_SLOTS];
  logic [3:0]  eff_wstrb_s [NUM_SLOTS];

  arb_state_t          state_r;
  slot_idx_t           cur_r, sel_s;
  logic [TO_WIDTH-1:0] to_cnt_r;
  logic                to_hit_s, done_s, busy_next_s, mem_wait_r;
  logic [31:0]         rdata_s;
  logic                m_req_r, m_we_r, err_r;
  logic [31:0]         m_addr_r, m_wdata_r;
  logic [3:0]          m_wstrb_r;
  logic                inst_rvalid_r, data_rvalid_r;
  logic [31:0]         inst_roaddr_r, inst_rdata_r, data_roaddr_r, data_rdata_r;

  assign cap_s = {INST_RDEN, DATA_RDEN, DATA_WREN} & {NUM_SLOTS{~mem_wait_r}};

  assign in_addr_s[SLOT_W]   = DATA_WADDR;
  assign in_addr_s[SLOT_DR]  = DATA_RIADDR;
  assign in_addr_s[SLOT_IR]  = INST_RIADDR;
  assign in_wdata_s[SLOT_W]  = DATA_WDATA;
  assign in_wdata_s[SLOT_DR] = 32'h0;
  assign in_wdata_s[SLOT_IR] = 32'h0;
  assign in_wstrb_s[SLOT_W]  = DATA_WSTRB;
  assign in_wstrb_s[SLOT_DR] = 4'h0;
  assign in_wstrb_s[SLOT_IR] = 4'h0;

  // A request captured this cycle is visible to IDLE at once, so the memory
  // request goes out the cycle after capture.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    mem_arb_slot u_slot (
      .clk       (CLK),
      .rst_n     (RST),
      .load      (cap_s[i]),
      .clear     (clr_s[i]),
      .addr      (in_addr_s[i]),
      .wdata     (in_wdata_s[i]),
      .wstrb     (in_wstrb_s[i]),
      .pending   (pend_s[i]),
      .held_addr (held_addr_s[i]),
      .held_wdata(held_wdata_s[i]),
      .held_wstrb(held_wstrb_s[i])
    );
    assign eff_addr_s[i]  = cap_s[i] ? in_addr_s[i]  : held_addr_s[i];
    assign eff_wdata_s[i] = cap_s[i] ? in_wdata_s[i] : held_wdata_s[i];
    assign eff_wstrb_s[i] = cap_s[i] ? in_wstrb_s[i] : held_wstrb_s[i];
    assign clr_s[i]       = done_s && (cur_r == slot_idx_t'(i));
  end

  if (TIMEOUT > 0) begin : g_to
    assign to_hit_s = (state_r == ST_BUSY) && !M_ACK &&
                      (to_cnt_r == TO_WIDTH'(TIMEOUT - 1));
  end else begin : g_no_to
    assign to_hit_s = 1'b0;
  end

  assign eff_pend_s  = pend_s | cap_s;
  assign sel_s       = pick_slot(eff_pend_s);
  assign done_s      = (state_r == ST_BUSY) && (M_ACK || to_hit_s);
  assign rdata_s     = M_ACK ? M_RDATA : 32'h0;
  assign pend_next_s = cap_s | (pend_s & ~clr_s);

  // Whether the FSM will be outside IDLE next cycle.
  always_comb begin
    busy_next_s = 1'b0;
    case (state_r)
      ST_IDLE: busy_next_s = |eff_pend_s;
      ST_BUSY: busy_next_s = 1'b1;
      ST_RESP: busy_next_s = 1'b0;
      default: busy_next_s = 1'b0;
    endcase
  end

  // Core stall: held while any slot or transaction remains outstanding.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_wait_r <= 1'b0;
    end else begin
      mem_wait_r <= busy_next_s | (|pend_next_s);
    end
  end

  // Arbitration FSM with the memory-side and response-side output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r       <= ST_IDLE;
      cur_r         <= SLOT_W;
      to_cnt_r      <= '0;
      m_req_r       <= 1'b0;
      m_we_r        <= 1'b0;
      m_addr_r      <= 32'h0;
      m_wstrb_r     <= 4'h0;
      m_wdata_r     <= 32'h0;
      inst_rvalid_r <= 1'b0;
      inst_roaddr_r <= 32'h0;
      inst_rdata_r  <= 32'h0;
      data_rvalid_r <= 1'b0;
      data_roaddr_r <= 32'h0;
      data_rdata_r  <= 32'h0;
      err_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|eff_pend_s) begin
            cur_r     <= sel_s;
            m_req_r   <= 1'b1;
            m_we_r    <= (sel_s == SLOT_W);
            m_addr_r  <= eff_addr_s[sel_s];
            m_wstrb_r <= eff_wstrb_s[sel_s];
            m_wdata_r <= eff_wdata_s[sel_s];
            to_cnt_r  <= '0;
            state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done_s) begin
            m_req_r <= 1'b0;
            state_r <= ST_RESP;
            if (to_hit_s) begin
              err_r <= 1'b1;
            end
            if (cur_r == SLOT_DR) begin
              data_rvalid_r <= 1'b1;
              data_roaddr_r <= m_addr_r;
              data_rdata_r  <= rdata_s;
            end else if (cur_r == SLOT_IR) begin
              inst_rvalid_r <= 1'b1;
              inst_roaddr_r <= m_addr_r;
              inst_rdata_r  <= rdata_s;
            end
          end else begin
            to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
          end
        end
        ST_RESP: begin
          inst_rvalid_r <= 1'b0;
          data_rvalid_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign MEM_WAIT    = mem_wait_r;
  assign M_REQ       = m_req_r;
  assign M_WE        = m_we_r;
  assign M_ADDR      = m_addr_r;
  assign M_WSTRB     = m_wstrb_r;
  assign M_WDATA     = m_wdata_r;
  assign INST_RVALID = inst_rvalid_r;
  assign INST_ROADDR = inst_roaddr_r;
  assign INST_RDATA  = inst_rdata_r;
  assign DATA_RVALID = data_rvalid_r;
  assign DATA_ROADDR = data_roaddr_r;
  assign DATA_RDATA  = data_rdata_r;
  assign ERR         = err_r;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the core's instruction and data memory ports and upstream of a single-port memory/bus slave.
- Captures up to three simultaneous core requests (instruction read, data read, data write) and serialises them onto one request/acknowledge memory channel.
- Returns read results in the core's ROADDR/RVALID/RDATA form.
- Drives MEM_WAIT, the core's stall input.

Parameters:
- TIMEOUT, 256: cycles to wait for MEM_ACK before aborting a transaction; 0 disables the timeout.
- TO_WIDTH, 9: width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- INST_RDEN  in  1  instruction read request.
- INST_RIADDR  in  32  instruction read address.
- INST_ROADDR  out  32  address of returned instruction.
- INST_RVALID  out  1  instruction data valid, one-cycle pulse.
- INST_RDATA  out  32  instruction data.
- DATA_RDEN  in  1  data read request.
- DATA_RIADDR  in  32  data read address.
- DATA_ROADDR  out  32  address of returned data.
- DATA_RVALID  out  1  data read valid, one-cycle pulse.
- DATA_RDATA  out  32  read data.
- DATA_WREN  in  1  data write request.
- DATA_WSTRB  in  4  byte strobes.
- DATA_WADDR  in  32  write address.
- DATA_WDATA  in  32  write data.
- MEM_WAIT  out  1  core stall; high while any captured request is outstanding.
- M_REQ  out  1  memory request, held until acknowledged.
- M_WE  out  1  1 = write, 0 = read.
- M_ADDR  out  32  memory address.
- M_WSTRB  out  4  byte strobes; 4'h0 on reads.
- M_WDATA  out  32  write data.
- M_ACK  in  1  memory accepts/completes the transaction this cycle.
- M_RDATA  in  32  read data, valid when M_ACK is high on a read.
- ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (RST low, asynchronous): all slots empty; FSM = IDLE. All outputs 0: MEM_WAIT, M_REQ, M_WE, *_RVALID, ERR; address and data outputs 32'h0, strobes 4'h0.
- Capture:
  - In any cycle with MEM_WAIT=0, each asserted enable (WREN, DATA_RDEN, INST_RDEN) latches its address/data/strobe into its own slot.
  - Requests presented while MEM_WAIT=1 are ignored; the core treats a request as accepted in the cycle it is sampled with MEM_WAIT=0.
- MEM_WAIT is registered. It rises the cycle after any capture and stays high while any slot is pending. It falls in the cycle after the final slot's response cycle.
- Service priority: write, then data read, then instruction read. This guarantees read-after-write ordering for a same-cycle write and read to the same address.
- FSM:
  - IDLE: if any slot is pending, load the highest-priority slot into M_* registers, set M_REQ=1, go to BUSY.
  - BUSY: hold M_* stable until M_ACK=1. On M_ACK: clear the slot, drop M_REQ, go to RESP.
  - RESP: one cycle. Read slots pulse their *_RVALID with *_ROADDR = slot address and *_RDATA = registered M_RDATA. Writes produce no response pulse. Then go to IDLE.
  - Minimum latency: capture at T, M_REQ at T+1, M_ACK at T+1 gives RVALID at T+2.
  - Back-to-back slots cost 3 cycles each (IDLE/BUSY/RESP); throughput is not optimised.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to BUSY. If it reaches TIMEOUT without M_ACK: drop M_REQ, set ERR=1 (sticky until reset), go to RESP.
  - A timed-out read returns RDATA=32'h0 with a normal RVALID pulse, so the core never deadlocks.
- M_ACK while not in BUSY is ignored.
- Reset asserted mid-transaction clears everything immediately. A late M_ACK after reset is ignored.
- *_RVALID is never high for two consecutive cycles. INST_RVALID and DATA_RVALID are never high together.
- Outputs are registered only; there are no combinational input-to-output paths.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, BUSY, RESP) and slot index constants (SLOT_W=0, SLOT_DR=1, SLOT_IR=2).
- One natural sub-module: mem_arb_slot, a request holding register with a pending flag, instantiated three times.

Test Plan:
- Single INST_RDEN, addr 32'h2000_0000; M_ACK in the first BUSY cycle with M_RDATA=32'h0000_0013 -> INST_RVALID at T+2, ROADDR=32'h2000_0000, RDATA=32'h0000_0013; MEM_WAIT high T+1..T+2, low at T+3.
- Same-cycle WREN (addr 32'h100, WDATA 32'hDEAD_BEEF, WSTRB 4'hF), DATA_RDEN (32'h100), INST_RDEN (32'h2000_0004) -> memory sees write, then read 32'h100, then read 32'h2000_0004 in that order; DATA_RDATA=32'hDEADBEEF from a model memory; MEM_WAIT low only after the instruction RVALID.
- M_ACK delayed 5 cycles -> M_REQ/M_ADDR/M_WE stable for all 5 cycles; single RVALID pulse afterwards.
- TIMEOUT=8, memory never acks a data read -> M_REQ drops after 8 BUSY cycles; DATA_RVALID with RDATA=32'h0; ERR=1 and stays 1 across later good transactions.
- Request issued while MEM_WAIT=1 -> not captured, no extra memory transaction.
- RST pulled low during BUSY, then a spurious M_ACK -> all outputs 0 immediately; no RVALID after release.
